aes_inv_cipher: RTL
===================

Name: aes_inv_cipher

Overview:
- Iterative AES-128 decryption core: the inverse of the encryption path driven by the AES top's mode 1.
- Accepts a 128-bit ciphertext and a 128-bit cipher key, expands the key once, and runs the inverse cipher at one round per clock.
- Presents the plaintext with a one-cycle done pulse.
- Sits beside the encryption datapath under the AES top, which selects it for mode 2 and feeds data_out to the display/assert logic.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, and any other value is a configuration error.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low (reset = 0 resets).
- start  input  1  request; sampled only in IDLE.
- new_key  input  1  1 = expand key_in for this request; 0 = reuse stored round keys.
- key_in  input  128  cipher key; bit 127 = key byte 0.
- data_in  input  128  ciphertext; bit 127 = state byte 0 (column-major, FIPS-197 order).
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle pulse when data_out is updated.
- data_out  output  128  plaintext; holds its value until the next done.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = IDLE; busy = 0, done = 0, data_out = 0.
  - key_valid flag cleared; round-key store cleared.
  - Reset mid-operation aborts the request with no done and no partial data_out update.
- FSM states: IDLE, KEY_EXP, INIT, ROUND, FINAL.
- IDLE:
  - start = 1 latches data_in (and key_in when expanding) and sets busy = 1 next cycle.
  - If new_key = 1 or key_valid = 0, go to KEY_EXP; otherwise go to INIT.
  - start in any other state is ignored, with no queueing.
- KEY_EXP:
  - 10 cycles; the round counter runs 1..10.
  - Each cycle computes rk[i] from rk[i-1] using RotWord, SubWord (forward S-box) and Rcon[i]. rk[0] = key_in.
  - Stores rk[0..10] in an 11x128 register file.
  - Sets key_valid = 1 on exit, then goes to INIT.
- INIT:
  - 1 cycle; state = state XOR rk[10]; round counter = 9; go to ROUND.
- ROUND:
  - One round per cycle: InvShiftRows -> InvSubBytes -> AddRoundKey(rk[cnt]) -> InvMixColumns.
  - Decrement cnt; when cnt reaches 1 and that round completes, go to FINAL.
  - Runs exactly 9 cycles.
- FINAL:
  - 1 cycle: InvShiftRows -> InvSubBytes -> AddRoundKey(rk[0]).
  - Result registered into data_out; done = 1 for exactly the following cycle; busy = 0 in that same cycle; return to IDLE.
- Latency, counted in edges after the edge that samples start until done is high:
  - 21 with key expansion (10 + 1 + 9 + 1).
  - 11 with a reused key.
- Back-to-back: a start asserted in the cycle done is high is accepted; throughput is one block per 12 cycles with a reused key.
- Arithmetic:
  - InvMixColumns uses GF(2^8) constant multiplies by 0x09, 0x0b, 0x0d, 0x0e, built from xtime chains with reduction polynomial 0x11b.
  - All byte operations are 8-bit and wrap modulo the field; there is no carry out.
- key_in and data_in may change after the start cycle without affecting the request in flight.
- new_key is ignored when start = 0.

Decomposition:
- Package aes_pkg holds:
  - forward and inverse S-box functions as 256-entry cases;
  - Rcon constant array [1..10];
  - xtime and gmul9/b/d/e functions;
  - FSM state enum;
  - NK = 4, NB = 4.
  - Shared with the encryption core.
- Sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/optional InvMixColumns, with a bypass_mix input used for FINAL.
- Key expansion, round-key store and FSM live in the top.

Test Plan:
- Vector 1 (FIPS-197 App. C.1): reset pulse low; start = 1, new_key = 1, key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> done 21 cycles later, data_out = 00112233445566778899aabbccddeeff, busy high for exactly 21 cycles.
- Vector 2 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32, new_key = 1 -> data_out = 3243f6a8885a308d313198a2e0370734.
- Key reuse: after vector 2, start with new_key = 0 and the same ciphertext -> done after 11 cycles with the same plaintext. Also, start with new_key = 0 directly after reset -> forced expansion, 21-cycle latency.
- Start while busy: pulse start with different data at cycle 5 of a request -> ignored; exactly one done; result unchanged.
- Reset mid-operation: drive reset = 0 asynchronously at cycle 8 of expansion -> busy, done and data_out go to 0 immediately. A subsequent new_key = 0 request expands anyway (key_valid cleared) and completes in 21 cycles.
- Back-to-back: start held high across the done cycle, with vector 1 followed by vector 1 using new_key = 0 -> second done exactly 12 cycles after the first.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-boxes, Rcon, GF(2^8) multiplies and the
// inverse-cipher FSM state encoding.
package aes_pkg;

  localparam int NK = 4;
  localparam int NB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_EXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } aes_state_e;

  // Byte 0x00 sits in the most significant byte of each table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Request/response bus of the AES-128 decryption core.
interface aes_inv_cipher_if;
  import aes_pkg::*;

  // start is a request taken only while the core is idle (busy low, or the
  // done cycle); there is no backpressure, so a start seen while busy is
  // dropped. done pulses for one cycle when data_out holds a new plaintext.
  logic         start;
  logic         new_key;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;
  aes_state_e   dbg_state;

  modport master (
    output start, new_key, key_in, data_in,
    input  busy, done, data_out, dbg_state
  );

  modport slave (
    input  start, new_key, key_in, data_in,
    output busy, done, data_out, dbg_state
  );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and InvMixColumns, the last skipped when bypass_mix_i is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         bypass_mix_i,
  output logic [127:0] state_o
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
            gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
            gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
            gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

  logic [127:0] ark;
  logic [127:0] mix;

  always_comb begin
    ark = '0;
    mix = '0;
    // Byte (row r, column c) lives at index 4c+r; row r rotates right by r.
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8 * (4 * c + r) -: 8] =
          inv_sbox(state_i[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]) ^
          rk_i[127 - 8 * (4 * c + r) -: 8];
      end
    end
    for (int c = 0; c < NB; c++) begin
      mix[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
    end
    state_o = bypass_mix_i ? ark : mix;
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one-time key expansion into an 11-entry
// round-key store, then one inverse round per clock.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input logic             CLK,
  input logic             reset,
  aes_inv_cipher_if.slave bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_inv_cipher: NR must be 10 for AES-128");
  end

  aes_state_e   state_q;
  logic [3:0]   cnt_q;
  logic [127:0] blk_q;
  logic [127:0] data_out_q;
  logic         busy_q;
  logic         done_q;
  logic         key_valid_q;
  logic [127:0] rk_q [0:NR];

  logic [127:0] rk_next;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic         is_final;

  function automatic logic [127:0] expand_key(input logic [127:0] prev,
                                              input logic [7:0]   rcon);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {prev[23:0], prev[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon, 24'h0};
    n0  = prev[127:96] ^ t;
    n1  = prev[95:64]  ^ n0;
    n2  = prev[63:32]  ^ n1;
    n3  = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign is_final  = (state_q == ST_FINAL);
  assign rk_next   = expand_key(rk_q[cnt_q - 4'd1], RCON[cnt_q]);
  assign round_key = is_final ? rk_q[0] : rk_q[cnt_q];

  aes_inv_round u_round (
    .state_i      (blk_q),
    .rk_i         (round_key),
    .bypass_mix_i (is_final),
    .state_o      (round_out)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            blk_q  <= bus.data_in;
            busy_q <= 1'b1;
            if (bus.new_key || !key_valid_q) begin
              rk_q[0] <= bus.key_in;
              cnt_q   <= 4'd1;
              state_q <= ST_KEY_EXP;
            end else begin
              state_q <= ST_INIT;
            end
          end
        end
        ST_KEY_EXP: begin
          rk_q[cnt_q] <= rk_next;
          if (cnt_q == 4'(NR)) begin
            key_valid_q <= 1'b1;
            state_q     <= ST_INIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_INIT: begin
          blk_q   <= blk_q ^ rk_q[NR];
          cnt_q   <= 4'(NR - 1);
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          blk_q <= round_out;
          if (cnt_q == 4'd1) state_q <= ST_FINAL;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_FINAL: begin
          data_out_q <= round_out;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_out  = data_out_q;
  assign bus.dbg_state = state_q;

endmodule
